mld_cyclic_encoder: RTL and testbench
=====================================

MLD_CYCLIC_ENCODER -- requirements
Module: mld_cyclic_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; all state changes on its rising edge except reset.
REQ-002 SHALL have: reset  input  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-003 SHALL have: start  input  1  request to encode the word on message; sampled only when not busy.
REQ-004 SHALL have: message  input  [0:10]  information bits; message[0] is transmitted first.
REQ-005 SHALL have: encoded_bit  output  1  serial codeword bit, registered.
REQ-006 SHALL have: bit_valid  output  1  high while encoded_bit carries a codeword bit.
REQ-007 SHALL have: busy  output  1  high while a frame is in progress.
REQ-008 SHALL have: done  output  1  one-cycle pulse after the last codeword bit.
REQ-009 SHALL have: encoded_vector  output  [0:14]  parallel copy of the last complete codeword.

Function
REQ-010 Code: (15,11) systematic cyclic code, g(x)=1+x+x^4; serial counterpart of the Multi_Step_MLD_decoder input stream.
REQ-011 Bit order: transmitted index k carries the coefficient of x^(14-k); k=0..10 is message[k], k=11..14 is parity p3,p2,p1,p0.
REQ-012 Parity: p(x) = x^4*m(x) mod g(x), computed bit-serially with a 4-bit LFSR (r0..r3): f=in^r3; r0<=f; r1<=r0^f; r2<=r1; r3<=r2.
REQ-013 States: IDLE, MSG (11 cycles), PARITY (4 cycles), DONE (1 cycle).
REQ-014 IDLE or DONE with start=1 at a clock edge: latch message, clear LFSR, go to MSG. Otherwise DONE->IDLE, IDLE holds.
REQ-015 Latency: first codeword bit (k=0) appears on encoded_bit with bit_valid=1 in the cycle right after the accepting edge.
REQ-016 MSG: emits message[k], feeds it into the LFSR, increments a 4-bit counter 0..10. After k=10, go to PARITY.
REQ-017 PARITY: emits r3, then shifts r3<=r2, r2<=r1, r1<=r0, r0<=0 with feedback disabled; k=11..14. After k=14, go to DONE.
REQ-018 bit_valid is high for exactly 15 consecutive cycles per frame. busy is high in MSG and PARITY only.
REQ-019 DONE: done=1, busy=0, bit_valid=0, encoded_bit=0. encoded_vector is updated with the full 15-bit codeword on entry to DONE.
REQ-020 start while busy is ignored; message changes while busy have no effect on the frame in progress.
REQ-021 start held high continuously: frames repeat with exactly one DONE cycle between them (16-cycle period).
REQ-022 When bit_valid=0, encoded_bit SHALL be 0.

Reset
REQ-023 reset=0, asserted at any time including mid-frame: state=IDLE, LFSR=0, counter=0, latched message=0, encoded_bit=0, bit_valid=0, busy=0, done=0, encoded_vector=0, with no done pulse for an aborted frame.
REQ-024 After reset deasserts, the first edge with start=1 begins a new frame normally.

Verification
REQ-025 message=000_0000_0001 (only message[10]=1), start pulse -> stream 00000000001 0011; encoded_vector=000000000010011; done one cycle after the last bit.
REQ-026 message=100_0000_0000 -> stream 10000000000 1001.
REQ-027 message=111_1111_1111 -> all 15 bits 1; message=0 -> all 15 bits 0, with bit_valid high for 15 cycles in both cases.
REQ-028 start held high with two different messages, message changed during the first frame -> first frame is unaffected; second frame's bit 0 is valid 16 cycles after the first frame's bit 0.
REQ-029 reset=0 pulsed at k=6 -> all outputs 0 immediately, no done pulse; a frame started afterwards encodes correctly.
REQ-030 Loopback: 15-cycle encoder stream fed into Multi_Step_MLD_decoder with load, single bit error injected at each position -> decoded_vector equals the error-free codeword.

Source files
------------

// File: rtl/mld_cyclic_encoder.sv
// Serial (15,11) systematic cyclic encoder, g(x) = 1 + x + x^4.
// Streams message[0..10] followed by parity p3..p0 and keeps a parallel copy of the codeword.
module mld_cyclic_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:10] message,
    output logic        encoded_bit,
    output logic        bit_valid,
    output logic        busy,
    output logic        done,
    output logic [0:14] encoded_vector
);

    typedef enum logic [1:0] {
        StIdle,
        StMsg,
        StParity,
        StDone
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [0:10] r_sh;
    logic [3:0]  r_lfsr;
    logic        r_bit;
    logic [0:14] r_cw;
    logic [0:14] r_vec;

    state_t      w_state_next;
    logic [3:0]  w_cnt_next;
    logic [0:10] w_sh_next;
    logic [3:0]  w_lfsr_next;
    logic        w_bit_next;
    logic [0:14] w_cw_next;
    logic [0:14] w_vec_next;

    logic        w_active;
    logic        w_fb;
    logic [3:0]  w_lfsr_absorb;
    logic [3:0]  w_lfsr_shift;

    assign w_active = (r_state == StMsg) || (r_state == StParity);

    // r_sh[0] is always the message bit currently on encoded_bit while in StMsg.
    assign w_fb          = r_sh[0] ^ r_lfsr[3];
    assign w_lfsr_absorb = {r_lfsr[2], r_lfsr[1], r_lfsr[0] ^ w_fb, w_fb};
    assign w_lfsr_shift  = {r_lfsr[2:0], 1'b0};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sh_next    = r_sh;
        w_lfsr_next  = r_lfsr;
        w_bit_next   = 1'b0;
        w_cw_next    = r_cw;
        w_vec_next   = r_vec;

        // Every transmitted bit is captured so the parallel copy matches the stream exactly.
        if (w_active) begin
            w_cw_next = {r_cw[1:14], r_bit};
        end

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next = StMsg;
                    w_cnt_next   = 4'd0;
                    w_sh_next    = message;
                    w_lfsr_next  = 4'd0;
                    w_bit_next   = message[0];
                end else begin
                    w_state_next = StIdle;
                end
            end
            StMsg: begin
                w_lfsr_next = w_lfsr_absorb;
                w_sh_next   = {r_sh[1:10], 1'b0};
                if (r_cnt == 4'd10) begin
                    w_state_next = StParity;
                    w_cnt_next   = 4'd11;
                    w_bit_next   = w_lfsr_absorb[3];
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                    w_bit_next = r_sh[1];
                end
            end
            StParity: begin
                w_lfsr_next = w_lfsr_shift;
                if (r_cnt == 4'd14) begin
                    w_state_next = StDone;
                    w_cnt_next   = 4'd0;
                    w_vec_next   = {r_cw[1:14], r_bit};
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                    w_bit_next = w_lfsr_shift[3];
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_sh    <= '0;
            r_lfsr  <= 4'd0;
            r_bit   <= 1'b0;
            r_cw    <= '0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sh    <= w_sh_next;
            r_lfsr  <= w_lfsr_next;
            r_bit   <= w_bit_next;
            r_cw    <= w_cw_next;
            r_vec   <= w_vec_next;
        end
    end

    assign encoded_bit    = r_bit;
    assign bit_valid      = w_active;
    assign busy           = w_active;
    assign done           = (r_state == StDone);
    assign encoded_vector = r_vec;

endmodule

// File: tb/tb_mld_cyclic_encoder.sv
// Scoreboard bench for mld_cyclic_encoder: stimulus queues hand-computed codewords,
// a negedge monitor reassembles each serial frame and checks it against the queue.
module tb_mld_cyclic_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [0:10] message = '0;
    logic        encoded_bit;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic [0:14] encoded_vector;

    mld_cyclic_encoder u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .message        (message),
        .encoded_bit    (encoded_bit),
        .bit_valid      (bit_valid),
        .busy           (busy),
        .done           (done),
        .encoded_vector (encoded_vector)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [0:14] exp_q[$];
    int          first_cyc[$];
    int          frames_done = 0;
    int          cyc = 0;
    int          mcnt = 0;
    logic [0:14] got = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: assembles frames from the serial stream and scores them at the done pulse.
    always @(negedge clk) begin
        logic [0:14] e;
        if (!reset) begin
            mcnt = 0;
        end else if (bit_valid) begin
            if (mcnt == 0) first_cyc.push_back(cyc);
            if (mcnt < 15) got[mcnt] = encoded_bit;
            mcnt++;
            check("busy_with_valid", 32'(busy), 32'd1);
        end else begin
            check("bit_zero_when_invalid", 32'(encoded_bit), 32'd0);
            if (done) begin
                check("frame_len", 32'(mcnt), 32'd15);
                check("busy_in_done", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("stream", 32'(got), 32'(e));
                    check("vector", 32'(encoded_vector), 32'(e));
                end
                frames_done++;
                mcnt = 0;
            end else if (mcnt != 0) begin
                flag("frame_cut_without_done");
                mcnt = 0;
            end
        end
    end

    task automatic wait_frames(input int n);
        for (int i = 0; i < 80 && frames_done < n; i++) @(posedge clk);
        if (frames_done < n) flag("timeout_waiting_done");
    endtask

    task automatic send(input logic [0:10] m, input logic [0:14] e);
        @(posedge clk);
        #1;
        message = m;
        start   = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("latency_valid", 32'(bit_valid), 32'd1);
        check("latency_bit0", 32'(encoded_bit), 32'(m[0]));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_bit"}, 32'(encoded_bit), 32'd0);
        check({name, "_valid"}, 32'(bit_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_vector"}, 32'(encoded_vector), 32'd0);
    endtask

    initial begin
        int n_before;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b1;

        send(11'b000_0000_0001, 15'b00000000001_0011);
        wait_frames(1);
        send(11'b100_0000_0000, 15'b10000000000_1001);
        wait_frames(2);
        send(11'b111_1111_1111, 15'b11111111111_1111);
        wait_frames(3);
        send(11'b000_0000_0000, 15'b00000000000_0000);
        wait_frames(4);

        // start and a new message while busy must not disturb the frame
        send(11'b000_0000_0010, 15'b00000000010_0110);
        repeat (4) @(posedge clk);
        #1;
        message = 11'b111_1111_1111;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frames(5);
        repeat (20) @(posedge clk);
        check("no_extra_frame", 32'(frames_done), 32'd5);

        // start held high: back-to-back frames, message changed mid-frame
        @(posedge clk);
        #1;
        message = 11'b100_0000_0000;
        start   = 1'b1;
        exp_q.push_back(15'b10000000000_1001);
        exp_q.push_back(15'b00000000001_0011);
        @(posedge clk);
        #1;
        message = 11'b000_0000_0001;
        wait_frames(6);
        #1;
        start = 1'b0;
        wait_frames(7);
        if (first_cyc.size() >= 2) begin
            check("back_to_back_period", 32'(first_cyc[$] - first_cyc[$-1]), 32'd16);
        end else begin
            flag("back_to_back_missing_frames");
        end

        // reset pulse at k=6 aborts the frame with no done pulse
        repeat (3) @(posedge clk);
        #1;
        message = 11'b111_1111_1111;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_abort_valid", 32'(bit_valid), 32'd1);
        check("pre_abort_bit", 32'(encoded_bit), 32'd1);
        n_before = frames_done;
        reset = 1'b0;
        #1;
        check_all_zero("abort_now");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        reset = 1'b1;
        repeat (20) @(posedge clk);
        check("no_done_after_abort", 32'(frames_done), 32'(n_before));

        send(11'b000_0000_0001, 15'b00000000001_0011);
        wait_frames(n_before + 1);
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
